// File: rtl/secded_mem_sequencer_if.sv
// rtl/secded_mem_sequencer_if.sv - data-memory port and SECDED decoder handshake bundle
interface secded_mem_sequencer_if #(
  parameter int AW = 8
);
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic          dec_req;
  logic [15:0]   dec_word;
  logic          dec_ack;
  logic [15:0]   dec_data;

  modport master (
    output mem_addr, mem_we, mem_wdata, dec_req, dec_word,
    input  mem_rdata, dec_ack, dec_data
  );

  modport slave (
    input  mem_addr, mem_we, mem_wdata, dec_req, dec_word,
    output mem_rdata, dec_ack, dec_data
  );
endinterface

// File: rtl/secded_mem_sequencer.sv
// rtl/secded_mem_sequencer.sv - walks SECDED messages through the decoder, writes results back
// Optional error statistics counters: define SECDED_SEQ_STATS_EN.
module secded_mem_sequencer #(
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 30,
  parameter int DST_BASE = 0,
  parameter int AW       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [7:0] err1_cnt,
  output logic [7:0] err2_cnt,
  secded_mem_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_LO, S_RD_HI, S_RD_CAP, S_DEC, S_WR_LO, S_WR_HI, S_DONE
  } state_t;

  localparam logic [6:0] LAST_IDX = 7'(NUM_MSG - 1);

  state_t        state, state_nxt;
  logic [6:0]    idx;
  logic [7:0]    lo_q, hi_q;
  logic [15:0]   res_q;
  logic          done_q;
  logic          start_ok;
  logic          ack_ok;
  logic [AW-1:0] src_addr, dst_addr;

  assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));
  assign ack_ok   = (state == S_DEC) && bus.dec_ack;
  // Byte addresses wrap modulo 2^AW by truncation.
  assign src_addr = AW'(SRC_BASE) + AW'({idx, 1'b0});
  assign dst_addr = AW'(DST_BASE) + AW'({idx, 1'b0});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      idx    <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
      res_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      // done follows DONE by one cycle and drops on the edge that accepts a restart
      done_q <= (state == S_DONE) && !start;
      case (state)
        S_IDLE, S_DONE: if (start_ok) idx <= '0;
        S_RD_HI:        lo_q <= bus.mem_rdata;
        S_RD_CAP:       hi_q <= bus.mem_rdata;
        S_DEC:          if (bus.dec_ack) res_q <= bus.dec_data;
        S_WR_HI:        if (idx != LAST_IDX) idx <= idx + 7'd1;
        default:        ;
      endcase
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    bus.dec_req   = 1'b0;
    bus.dec_word  = '0;
    busy          = (state != S_IDLE) && (state != S_DONE);
    done          = done_q;
    case (state)
      S_IDLE, S_DONE: if (start_ok) state_nxt = S_RD_LO;
      S_RD_LO: begin
        bus.mem_addr = src_addr;
        state_nxt    = S_RD_HI;
      end
      S_RD_HI: begin
        bus.mem_addr = src_addr + AW'(1);
        state_nxt    = S_RD_CAP;
      end
      S_RD_CAP: state_nxt = S_DEC;
      S_DEC: begin
        bus.dec_req  = 1'b1;
        bus.dec_word = {hi_q, lo_q};
        if (bus.dec_ack) state_nxt = S_WR_LO;
      end
      S_WR_LO: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = dst_addr;
        bus.mem_wdata = res_q[7:0];
        state_nxt     = S_WR_HI;
      end
      S_WR_HI: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = dst_addr + AW'(1);
        bus.mem_wdata = res_q[15:8];
        state_nxt     = (idx == LAST_IDX) ? S_DONE : S_RD_LO;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef SECDED_SEQ_STATS_EN
  logic [7:0] err1_q, err2_q;

  // A double-error flag takes precedence; the counters saturate rather than wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err1_q <= '0;
      err2_q <= '0;
    end else if (start_ok) begin
      err1_q <= '0;
      err2_q <= '0;
    end else if (ack_ok) begin
      if (bus.dec_data[15]) begin
        if (err2_q != 8'hFF) err2_q <= err2_q + 8'd1;
      end else if (bus.dec_data[14]) begin
        if (err1_q != 8'hFF) err1_q <= err1_q + 8'd1;
      end
    end
  end

  assign err1_cnt = err1_q;
  assign err2_cnt = err2_q;
`else
  logic unused_ack;
  assign unused_ack = ack_ok;
  assign err1_cnt   = '0;
  assign err2_cnt   = '0;
`endif

endmodule

// File: tb/tb_secded_mem_sequencer.sv
// tb/tb_secded_mem_sequencer.sv - scoreboard bench for secded_mem_sequencer
module tb_secded_mem_sequencer;
  localparam int NUM_MSG  = 15;
  localparam int SRC_BASE = 30;
  localparam int DST_BASE = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic busy_a, done_a, busy_b, done_b;
  logic [7:0] e1_a, e2_a, e1_b, e2_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  secded_mem_sequencer_if #(.AW(8)) bus_a ();
  secded_mem_sequencer_if #(.AW(8)) bus_b ();

  secded_mem_sequencer u_dut (
    .clk      (clk),
    .reset    (rst_n),
    .start    (start_a),
    .busy     (busy_a),
    .done     (done_a),
    .err1_cnt (e1_a),
    .err2_cnt (e2_a),
    .bus      (bus_a.master)
  );

  secded_mem_sequencer #(.NUM_MSG(1), .SRC_BASE(254), .DST_BASE(255), .AW(8)) u_dut_b (
    .clk      (clk),
    .reset    (rst_n),
    .start    (start_b),
    .busy     (busy_b),
    .done     (done_b),
    .err1_cnt (e1_b),
    .err2_cnt (e2_b),
    .bus      (bus_b.master)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] dec_model(input logic [15:0] w);
    return {w[15], w[15] ? 1'b0 : w[14], 3'b000, w[10:0] ^ 11'h5A3};
  endfunction

  // memory model: synchronous read, loader port used only while the DUTs are idle
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic       ld_en = 1'b0;
  logic       ld_sel = 1'b0;
  logic [7:0] ld_addr = '0;
  logic [7:0] ld_data = '0;

  always @(posedge clk) begin
    if (ld_en) begin
      if (ld_sel) mem_b[ld_addr] <= ld_data;
      else        mem_a[ld_addr] <= ld_data;
    end else begin
      if (bus_a.mem_we) mem_a[bus_a.mem_addr] <= bus_a.mem_wdata;
      if (bus_b.mem_we) mem_b[bus_b.mem_addr] <= bus_b.mem_wdata;
    end
    bus_a.mem_rdata <= mem_a[bus_a.mem_addr];
    bus_b.mem_rdata <= mem_b[bus_b.mem_addr];
  end

  assign bus_b.dec_ack  = bus_b.dec_req;
  assign bus_b.dec_data = dec_model(bus_b.dec_word);

  logic [15:0] words   [NUM_MSG];
  logic [15:0] exp_res [NUM_MSG];
  logic [15:0] exp_q [$];
  logic [15:0] wq [$];
  int ack_delay = 0;

  // decoder responder for DUT A: acks after ack_delay extra request cycles
  int          wcnt = 0;
  logic [15:0] held = '0;
  always @(negedge clk) begin
    if (!rst_n || !bus_a.dec_req) begin
      bus_a.dec_ack  = 1'b0;
      bus_a.dec_data = '0;
      wcnt           = 0;
    end else begin
      if (wcnt == 0) held = bus_a.dec_word;
      else chk("dec_word_stable", 32'(bus_a.dec_word), 32'(held));
      if (wcnt == ack_delay) begin
        bus_a.dec_ack  = 1'b1;
        bus_a.dec_data = dec_model(bus_a.dec_word);
        if (wq.size() == 0) chk("dec_word_unexpected", 32'(bus_a.dec_word), 32'hFFFF_FFFF);
        else chk("dec_word", 32'(bus_a.dec_word), 32'(wq.pop_front()));
        wcnt = 0;
      end else begin
        bus_a.dec_ack = 1'b0;
        wcnt++;
      end
    end
  end

  int we_cnt_a = 0;
  always @(negedge clk) begin
    if (rst_n && bus_a.mem_we) begin
      logic [15:0] e;
      we_cnt_a++;
      if (exp_q.size() == 0) chk("wr_unexpected", 32'(bus_a.mem_addr), 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus_a.mem_addr), 32'(e[15:8]));
        chk("wr_data", 32'(bus_a.mem_wdata), 32'(e[7:0]));
      end
    end
  end

  task automatic load(input logic sel, input logic [7:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_sel = sel; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic push_run();
    for (int i = 0; i < NUM_MSG; i++) begin
      wq.push_back(words[i]);
      exp_q.push_back({8'(DST_BASE + 2*i), exp_res[i][7:0]});
      exp_q.push_back({8'(DST_BASE + 2*i + 1), exp_res[i][15:8]});
    end
  endtask

  task automatic check_results(input string tag);
    for (int i = 0; i < NUM_MSG; i++)
      chk(tag, 32'({mem_a[8'(DST_BASE + 2*i + 1)], mem_a[8'(DST_BASE + 2*i)]}), 32'(exp_res[i]));
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("wq_drained", 32'(wq.size()), 32'd0);
  endtask

  task automatic run_a(input int pulse_at, output int cyc);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    chk("done_clr_on_start", 32'(done_a), 32'd0);
    chk("busy_on_start", 32'(busy_a), 32'd1);
    chk("err1_clr_on_start", 32'(e1_a), 32'd0);
    chk("err2_clr_on_start", 32'(e2_a), 32'd0);
    cyc = 0;
    while (cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      start_a = (cyc == pulse_at);
      if (done_a) break;
    end
    start_a = 1'b0;
    chk("done_level", 32'(done_a), 32'd1);
    chk("busy_in_done", 32'(busy_a), 32'd0);
  endtask

  task automatic check_stats();
`ifdef SECDED_SEQ_STATS_EN
    chk("err1_cnt", 32'(e1_a), 32'd9);
    chk("err2_cnt", 32'(e2_a), 32'd4);
`else
    chk("err1_cnt_tied", 32'(e1_a), 32'd0);
    chk("err2_cnt_tied", 32'(e2_a), 32'd0);
`endif
  endtask

  initial begin
    int cyc;
    int we0;
    bit found;
    logic [15:0] wb;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_mem_addr", 32'(bus_a.mem_addr), 32'd0);
    chk("rst_mem_we", 32'(bus_a.mem_we), 32'd0);
    chk("rst_mem_wdata", 32'(bus_a.mem_wdata), 32'd0);
    chk("rst_dec_req", 32'(bus_a.dec_req), 32'd0);
    chk("rst_dec_word", 32'(bus_a.dec_word), 32'd0);
    chk("rst_err1", 32'(e1_a), 32'd0);
    chk("rst_err2", 32'(e2_a), 32'd0);
    rst_n = 1'b1;

    // 4 double-error, 9 single-error, 2 clean messages
    for (int i = 0; i < NUM_MSG; i++) begin
      words[i] = 16'($urandom);
      if (i < 4)       words[i][15]    = 1'b1;
      else if (i < 13) words[i][15:14] = 2'b01;
      else             words[i][15:14] = 2'b00;
      exp_res[i] = dec_model(words[i]);
      load(1'b0, 8'(SRC_BASE + 2*i), words[i][7:0]);
      load(1'b0, 8'(SRC_BASE + 2*i + 1), words[i][15:8]);
      load(1'b0, 8'(DST_BASE + 2*i), 8'hEE);
      load(1'b0, 8'(DST_BASE + 2*i + 1), 8'hEE);
    end

    // abort during message 3 WR_LO
    push_run();
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(negedge clk);
      if (bus_a.mem_we && bus_a.mem_addr == 8'(DST_BASE + 6)) found = 1'b1;
    end
    chk("abort_point_reached", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_mem_we", 32'(bus_a.mem_we), 32'd0);
    chk("abort_mem_addr", 32'(bus_a.mem_addr), 32'd0);
    chk("abort_mem_wdata", 32'(bus_a.mem_wdata), 32'd0);
    chk("abort_dec_req", 32'(bus_a.dec_req), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    exp_q.delete();
    wq.delete();
    for (int i = 0; i < 3; i++)
      chk("abort_dst_kept", 32'({mem_a[8'(DST_BASE + 2*i + 1)], mem_a[8'(DST_BASE + 2*i)]}), 32'(exp_res[i]));
    chk("abort_dst6_untouched", 32'(mem_a[8'(DST_BASE + 6)]), 32'hEE);
    rst_n = 1'b1;

    // clean zero-wait run
    push_run();
    we0 = we_cnt_a;
    run_a(0, cyc);
    chk("latency_zero_wait", 32'(cyc), 32'd91);
    chk("mem_we_pulses", 32'(we_cnt_a - we0), 32'd30);
    check_results("result_zero_wait");
    check_stats();

    // restart from DONE with a 3-cycle ack delay
    ack_delay = 3;
    push_run();
    run_a(0, cyc);
    chk("latency_ack_delay", 32'(cyc), 32'd136);
    check_results("result_ack_delay");
    check_stats();

    // start while busy is ignored
    ack_delay = 0;
    push_run();
    we0 = we_cnt_a;
    run_a(10, cyc);
    chk("latency_start_ignored", 32'(cyc), 32'd91);
    chk("mem_we_pulses_2", 32'(we_cnt_a - we0), 32'd30);
    check_results("result_start_ignored");

    // boundary instance: single message, addresses wrap
    wb = 16'h4C39;
    load(1'b1, 8'd254, wb[7:0]);
    load(1'b1, 8'd255, wb[15:8]);
    load(1'b1, 8'd0, 8'hEE);
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    cyc = 0;
    chk("bnd_rd_lo_addr", 32'(bus_b.mem_addr), 32'd254);
    while (cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) chk("bnd_rd_hi_addr", 32'(bus_b.mem_addr), 32'd255);
      if (cyc == 4) begin
        chk("bnd_wr_lo_we", 32'(bus_b.mem_we), 32'd1);
        chk("bnd_wr_lo_addr", 32'(bus_b.mem_addr), 32'd255);
      end
      if (cyc == 5) begin
        chk("bnd_wr_hi_we", 32'(bus_b.mem_we), 32'd1);
        chk("bnd_wr_hi_addr", 32'(bus_b.mem_addr), 32'd0);
      end
      if (done_b) break;
    end
    chk("bnd_latency", 32'(cyc), 32'd7);
    chk("bnd_result", 32'({mem_b[0], mem_b[255]}), 32'(dec_model(wb)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/secded_mem_sequencer.md
Name: secded_mem_sequencer

Overview:
- Hardware engine that walks a block of SECDED-encoded 16-bit messages in the byte-wide data memory.
- Per message: reads the two bytes, hands the word to the SECDED decoder over a req/ack handshake, and writes the 16-bit decoded result back to a destination block.
- Decoded result format: {dbl_flag, sgl_flag, 3'b0, data[10:0]}.
- Sits beside the core as a second data-memory master; owns the memory port while `busy` is high.

Parameters:
- NUM_MSG, 15: number of 16-bit messages processed per run (1..127).
- SRC_BASE, 30: byte address of message 0 low byte. High byte is at +1; message i is at SRC_BASE+2i.
- DST_BASE, 0: byte address of result 0 low byte; result i is at DST_BASE+2i.
- AW, 8: data memory address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  run request, sampled only in IDLE or DONE.
- busy  out  1  high while a run is in progress.
- done  out  1  level, high in DONE until the next start or reset.
- mem_addr  out  AW  data memory byte address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  8  memory write data.
- mem_rdata  in  8  memory read data, valid one cycle after its address (synchronous read).
- dec_req  out  1  decoder request.
- dec_word  out  16  codeword {hi, lo} presented to the decoder.
- dec_ack  in  1  decoder acknowledge; dec_data is valid in the same cycle.
- dec_data  in  16  decoded result.
- err1_cnt  out  8  single-error count (optional feature).
- err2_cnt  out  8  double-error count (optional feature).

Behaviour:
- Reset (reset low, asynchronous): state to IDLE. busy=0, done=0, mem_addr=0, mem_we=0, mem_wdata=0, dec_req=0, dec_word=0, message index=0, err counters=0.
- States: IDLE, RD_LO, RD_HI, RD_CAP, DEC, WR_LO, WR_HI, DONE.
- IDLE: start=1 goes to RD_LO and sets index=0. busy rises in the first RD_LO cycle.
- RD_LO: mem_addr=SRC_BASE+2i. Go to RD_HI.
- RD_HI: mem_addr=SRC_BASE+2i+1; capture mem_rdata as lo. Go to RD_CAP.
- RD_CAP: capture mem_rdata as hi. Go to DEC.
- DEC: dec_req=1 and dec_word={hi,lo}, both held stable until dec_ack is sampled high.
  - On ack: capture dec_data into a result register and go to WR_LO.
  - An ack in the first DEC cycle costs exactly one cycle.
  - dec_ack outside DEC is ignored.
- WR_LO: mem_we=1, mem_addr=DST_BASE+2i, mem_wdata=result[7:0].
- WR_HI: mem_we=1, mem_addr=DST_BASE+2i+1, mem_wdata=result[15:8].
  - If i==NUM_MSG-1, go to DONE; otherwise i++ and go to RD_LO.
- DONE: done=1, busy=0.
  - start=1 clears done in the next cycle, restarts at index 0 and enters RD_LO.
- start while busy is ignored; no queuing.
- mem_we is high only in WR_LO and WR_HI. mem_addr and mem_wdata are 0 in IDLE and DONE.
- Address arithmetic is modulo 2^AW (wraps, no error).
- Latency with zero-wait ack: 6 cycles per message. Start sampled at edge k gives done high after edge k+6*NUM_MSG+1. Each extra ack wait cycle adds one cycle.
- Reset asserted mid-run aborts immediately. Memory bytes already written stay written; no partial-write protection.

Optional Feature:
- Macro: SECDED_SEQ_STATS_EN.
- Defined:
  - On each ack, if dec_data[15]=1, increment err2_cnt.
  - Else if dec_data[14]=1, increment err1_cnt.
  - Both counters saturate at 255, clear on reset and on each accepted start, and hold their value in DONE.
- Undefined: err1_cnt and err2_cnt are tied to 0 and no counter flops exist.

Test Plan:
- Reset mid-run: assert reset low during message 3 WR_LO.
  - Outputs go to their reset values with no clock edge.
  - dst bytes 0..5 updated, byte 6 not.
  - A fresh start reprocesses all 15 messages.
- Clean run, NUM_MSG=15, SRC_BASE=30, DST_BASE=0, decoder model acks in the first DEC cycle:
  - done asserts 91 cycles after start.
  - core[2i] and core[2i+1] equal the model's 16-bit result for each i.
  - mem_we pulses exactly 30 times.
- Ack delay: decoder acks 3 cycles after req (4 DEC cycles).
  - dec_word is stable throughout DEC.
  - done asserts at 91+45=136 cycles.
  - Results are identical to the zero-wait run.
- Start handling:
  - start pulsed at cycle 10 of a run has no effect; done still at 91.
  - start in DONE drops done next cycle, and a second run completes.
- Stats (macro defined): model flags 9 single-error messages, 4 double-error (dec_data[15]=1) and 2 clean.
  - err1_cnt=9 and err2_cnt=4 at done.
  - Both counters read 0 one cycle after a restart.
- Boundary: NUM_MSG=1, SRC_BASE=254, DST_BASE=255.
  - Reads hit 254 and 255; writes hit 255 then 0 (wrap).
  - done asserts after 7 cycles.
